// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer: steps the light FSM on with one-cycle enables, holds for a
// pseudo-random time, issues lights-out, then times the driver's reaction.
module f1_start_ctrl #(
    parameter int TICK_CYCLES = 100,
    parameter int DELAY_UNIT  = 50,
    parameter int RT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                react,
    output logic                light_en,
    output logic [3:0]          lit,
    output logic                lights_out,
    output logic                busy,
    output logic                react_valid,
    output logic [RT_WIDTH-1:0] react_time,
    output logic                jump_start
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam int PW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

    typedef enum logic [2:0] {IDLE, LIGHT, HOLD, REACT, ABORT} state_t;

    state_t              state_q;
    logic [6:0]          lfsr_q;
    logic [TW-1:0]       tick_q;
    logic [PW-1:0]       pre_q;
    logic [6:0]          dcnt_q;
    logic [RT_WIDTH-1:0] rcnt_q;
    logic [RT_WIDTH-1:0] react_time_q;
    logic [3:0]          lit_q;
    // n_q counts enables already issued; lit_q trails it by one cycle like the light FSM
    logic [3:0]          n_q;
    logic                light_en_q;
    logic                lights_out_q;
    logic                react_valid_q;
    logic                jump_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lfsr_q        <= 7'h01;
            tick_q        <= '0;
            pre_q         <= '0;
            dcnt_q        <= '0;
            rcnt_q        <= '0;
            react_time_q  <= '0;
            lit_q         <= '0;
            n_q           <= '0;
            light_en_q    <= 1'b0;
            lights_out_q  <= 1'b0;
            react_valid_q <= 1'b0;
            jump_q        <= 1'b0;
        end else begin
            lfsr_q        <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
            light_en_q    <= 1'b0;
            lights_out_q  <= 1'b0;
            react_valid_q <= 1'b0;
            jump_q        <= 1'b0;
            if (light_en_q) lit_q <= (lit_q == 4'd8) ? 4'd0 : lit_q + 4'd1;

            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q <= LIGHT;
                        tick_q  <= '0;
                    end
                end
                LIGHT: begin
                    if (react) begin
                        jump_q  <= 1'b1;
                        state_q <= ABORT;
                    end else if (tick_q == TW'(TICK_CYCLES - 1)) begin
                        tick_q     <= '0;
                        light_en_q <= 1'b1;
                        n_q        <= n_q + 4'd1;
                        if (n_q == 4'd7) begin
                            dcnt_q  <= lfsr_q;
                            pre_q   <= '0;
                            state_q <= HOLD;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                HOLD: begin
                    if (react) begin
                        jump_q  <= 1'b1;
                        state_q <= ABORT;
                    end else if (pre_q == PW'(DELAY_UNIT - 1)) begin
                        pre_q <= '0;
                        if (dcnt_q == 7'd1) begin
                            light_en_q   <= 1'b1;
                            lights_out_q <= 1'b1;
                            n_q          <= '0;
                            rcnt_q       <= RT_WIDTH'(1);
                            state_q      <= REACT;
                        end else begin
                            dcnt_q <= dcnt_q - 7'd1;
                        end
                    end else begin
                        pre_q <= pre_q + PW'(1);
                    end
                end
                REACT: begin
                    // Timeout reports all-ones, which is exactly rcnt_q at that point
                    if (react || rcnt_q == {RT_WIDTH{1'b1}}) begin
                        react_time_q  <= rcnt_q;
                        react_valid_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        rcnt_q <= rcnt_q + RT_WIDTH'(1);
                    end
                end
                ABORT: begin
                    if (n_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        light_en_q <= 1'b1;
                        if (n_q == 4'd8) begin
                            n_q     <= '0;
                            state_q <= IDLE;
                        end else begin
                            n_q <= n_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign light_en    = light_en_q;
    assign lit         = lit_q;
    assign lights_out  = lights_out_q;
    assign busy        = (state_q != IDLE);
    assign react_valid = react_valid_q;
    assign react_time  = react_time_q;
    assign jump_start  = jump_q;
endmodule
